// File: rtl/regfile_wr_initiator.sv
// -----------------------------------------------------------------------------
// regfile_wr_initiator
//
// Write-side initiator for one regfile write port of the v_tile. Vector write
// packets arrive from tile routing through a valid/ready handshake and are
// buffered in a small FIFO. The head packet is driven onto the regfile
// wen/w_data port and held there until the regfile answers with wr_ack. A
// request that never gets an ack is dropped after `timeout` cycles and a
// sticky error is raised.
//
// Handshake (upstream): a packet is transferred on every rising edge where
// in_valid && in_ready. in_valid/in_data may change freely while in_ready is
// low. in_ready depends only on the registered FIFO count (and reset), never
// on in_valid or on a same-cycle pop, so a full FIFO never accepts a packet.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   in_valid     in   upstream packet valid
//   in_ready     out  FIFO can accept a packet
//   in_data      in   packet lanes [num_inputs-1:0], each `width` bits
//   wen          out  regfile write enable
//   w_data       out  regfile write data lanes [num_inputs-1:0]
//   wr_ack       in   regfile write acknowledge
//   clr_err      in   synchronous clear of err_timeout/stray_ack/drop_cnt
//   busy         out  FIFO non-empty or FSM not idle
//   count        out  FIFO occupancy
//   err_timeout  out  sticky: a request timed out
//   stray_ack    out  sticky: wr_ack seen while no request was outstanding
//   drop_cnt     out  dropped request count, saturating at 255
//   dbg_state    out  current FSM state (IDLE=0, REQ=1, GAP=2)
// -----------------------------------------------------------------------------
module regfile_wr_initiator #(
  parameter int width      = 16,
  parameter int num_inputs = 4,
  parameter int depth      = 4,
  parameter int timeout    = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [width-1:0]          in_data [num_inputs-1:0],
  output logic                      wen,
  output logic [width-1:0]          w_data  [num_inputs-1:0],
  input  logic                      wr_ack,
  input  logic                      clr_err,
  output logic                      busy,
  output logic [$clog2(depth):0]    count,
  output logic                      err_timeout,
  output logic                      stray_ack,
  output logic [7:0]                drop_cnt,
  output logic [1:0]                dbg_state
);

  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;
  localparam int PW = width * num_inputs;
  localparam int TW = (timeout > 1) ? $clog2(timeout) : 1;
  localparam bit TO_EN = (timeout != 0);
  // Last timer value of a request; unused when the timeout is disabled.
  localparam logic [TW-1:0] TMAX = TW'((timeout > 0) ? timeout - 1 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic            wen_q, wen_d;
  logic [PW-1:0]   wdata_q, wdata_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            err_q, err_d;
  logic            stray_q, stray_d;
  logic [7:0]      drop_q, drop_d;
  logic [PW-1:0]   mem_q [depth];

  logic            push;
  logic            pop;
  logic            drop;
  logic            stray_ev;
  logic [PW-1:0]   in_pack;
  logic [7:0]      drop_base;

  // ---------------------------------------------------------------------------
  // Lane packing
  // ---------------------------------------------------------------------------
  always_comb begin
    in_pack = '0;
    for (int i = 0; i < num_inputs; i++) begin
      in_pack[i*width +: width] = in_data[i];
    end
  end

  always_comb begin
    for (int i = 0; i < num_inputs; i++) begin
      w_data[i] = wdata_q[i*width +: width];
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  // Gating with reset keeps in_ready low while reset is held, even though the
  // count register already reads zero.
  assign in_ready = reset && (count_q < CW'(depth));
  assign push     = in_valid && in_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is not reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_pack;
    end
  end

  // ---------------------------------------------------------------------------
  // Request FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    wen_d   = 1'b0;
    wdata_d = wdata_q;
    timer_d = timer_q;
    pop     = 1'b0;
    drop    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          wdata_d = mem_q[rd_ptr_q];
          wen_d   = 1'b1;
          timer_d = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        wen_d = 1'b1;
        // An ack in the last timer cycle still counts as a completed write.
        if (wr_ack) begin
          pop     = 1'b1;
          wen_d   = 1'b0;
          state_d = GAP;
        end else if (TO_EN && (timer_q == TMAX)) begin
          pop     = 1'b1;
          drop    = 1'b1;
          wen_d   = 1'b0;
          state_d = GAP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      GAP: begin
        // One forced low cycle so back-to-back writes are always separated.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sticky error reporting; a same-cycle event wins over clr_err.
  // ---------------------------------------------------------------------------
  assign stray_ev  = wr_ack && (state_q != REQ);
  assign drop_base = clr_err ? 8'd0 : drop_q;

  always_comb begin
    err_d   = (clr_err ? 1'b0 : err_q) | drop;
    stray_d = (clr_err ? 1'b0 : stray_q) | stray_ev;
    drop_d  = drop_base;
    if (drop && (drop_base != 8'hFF)) begin
      drop_d = drop_base + 8'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      wen_q    <= 1'b0;
      wdata_q  <= '0;
      timer_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      stray_q  <= 1'b0;
      drop_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      wen_q    <= wen_d;
      wdata_q  <= wdata_d;
      timer_q  <= timer_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
      stray_q  <= stray_d;
      drop_q   <= drop_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign wen         = wen_q;
  assign count       = count_q;
  assign busy        = (count_q != '0) || (state_q != IDLE);
  assign err_timeout = err_q;
  assign stray_ack   = stray_q;
  assign drop_cnt    = drop_q;
  assign dbg_state   = state_q;

endmodule

// File: doc/regfile_wr_initiator.md
Name: regfile_wr_initiator

Overview:
Write-side initiator for one regfile write port in the v_tile. Accepts vector write packets from tile routing logic through a valid/ready handshake and buffers them in a small FIFO. Drives the regfile wen/w_data port and holds each request until the regfile answers with wr_ack. A timeout drops stuck requests and raises a sticky error.

Parameters:
width, 16, bits per data lane (matches regfile width)
num_inputs, 4, lanes per write packet (matches regfile num_inputs)
depth, 4, FIFO entries; power of 2, at least 2
timeout, 32, cycles to wait for wr_ack before dropping the request; 0 disables the timeout

Ports:
clk  in  1  clock; all logic is rising-edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  upstream packet valid
in_ready  out  1  FIFO can accept a packet
in_data  in  width x num_inputs  packet lanes, unpacked array [num_inputs-1:0]
wen  out  1  regfile write enable, connects to wen1/wen2
w_data  out  width x num_inputs  regfile write data, unpacked array [num_inputs-1:0]
wr_ack  in  1  regfile write acknowledge, sampled on the rising edge
clr_err  in  1  synchronous clear for err_timeout, stray_ack and drop_cnt
busy  out  1  FIFO non-empty or FSM not IDLE
count  out  $clog2(depth)+1  current FIFO occupancy
err_timeout  out  1  sticky: at least one request timed out
stray_ack  out  1  sticky: wr_ack seen outside the REQ state
drop_cnt  out  8  number of dropped requests; saturates at 255

Behaviour:
- Reset (reset=0, asynchronous): wen=0, w_data all lanes 0, FIFO flushed, count=0, FSM=IDLE, timer=0, err_timeout=0, stray_ack=0, drop_cnt=0. in_ready=0 while reset is asserted and 1 in the first cycle after release.
- An assertion mid-request drops wen immediately, without waiting for a clock. The in-flight packet and all buffered packets are lost.
- FIFO:
  - Push when in_valid && in_ready. in_ready = (count < depth); it comes from registered count only.
  - When full, a same-cycle pop does not enable a push.
  - Pop only on completion or drop of the head request.
  - Pointers wrap modulo depth. count goes up/down by 1, or stays unchanged on simultaneous push+pop.
- FSM states: IDLE, REQ, GAP.
  - IDLE: if count>0, latch FIFO head into w_data, set wen=1, clear timer, go to REQ. Otherwise stay; wen=0.
  - REQ: wen=1 and w_data held stable.
    - If wr_ack=1: pop, wen=0, go to GAP.
    - Else if timeout!=0 and timer==timeout-1: pop (drop), set err_timeout, increment drop_cnt (saturating), wen=0, go to GAP.
    - Else timer+1.
  - GAP: wen=0 for exactly one cycle, then IDLE. This guarantees the regfile sees a wen deassertion between requests.
  - w_data keeps its last value outside REQ.
- Latency:
  - A packet pushed at edge N into an empty IDLE block gives wen=1 after edge N+1.
  - wr_ack sampled at edge M gives wen=0 after M; the next request has wen=1 after M+2.
  - Maximum throughput is one write per 3 cycles when wr_ack arrives in the first REQ cycle.
- wr_ack has priority over the timeout when both fall on the same cycle: the request completes and no error is raised.
- wr_ack=1 in IDLE or GAP: ignored for data purposes, stray_ack=1.
- clr_err=1 clears all three error outputs at the next edge. If an error event occurs in the same cycle, the event wins.
- busy = (count!=0) || (state!=IDLE).

Test Plan:
- Reset, then push one packet {1111,2222,3333,4444}; respond with wr_ack one cycle after wen rises -> wen high exactly 2 cycles, w_data matches lanes 0..3, count returns to 0, busy=0 after GAP.
- Push 4 packets back-to-back with wr_ack withheld -> in_ready=0 after the 4th push and a 5th in_valid is not accepted. Then ack each -> the regfile sees exactly 4 writes in FIFO order, with wen low for at least 1 cycle between them.
- timeout=8, push {AAAA,…} and never ack -> wen drops after 8 REQ cycles, err_timeout=1, drop_cnt=1, next packet is issued. Then pulse clr_err -> all error outputs are 0.
- wr_ack on the same cycle as timer==timeout-1 -> completed write, err_timeout stays 0, drop_cnt unchanged.
- Pulse wr_ack while IDLE with an empty FIFO -> stray_ack=1, no pop, count stays 0.
- Assert reset while wen=1 with 3 packets queued -> wen=0 before the next clk edge, count=0; after release, no write is issued without a new push.
